// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and constants for the multi-cycle RV32I-subset
//                control path: FSM state encoding, major opcodes, and the
//                ALU operand / operation select codes also used by the
//                datapath top.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Controller states. IDLE must stay at 0 because it is the reset state
    // and the value seen on the debug state output out of reset.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    // Major opcodes (instr[6:0]) understood by the controller.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Branch sense (instr[14:12]).
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALU operand A select.
    localparam logic [1:0] ALU_A_PC     = 2'b00;
    localparam logic [1:0] ALU_A_RS1    = 2'b01;
    localparam logic [1:0] ALU_A_OLD_PC = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

    // Operation class handed to ALU_Ctrl.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    // Branch resolution from the rs1-rs2 subtraction zero flag. Branch
    // kinds other than beq/bne are not supported and fall through.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_decode
//  Description : Purely combinational output decoder for the multi-cycle
//                controller. Maps the current state (plus the memory ready,
//                ALU zero and funct3 inputs where needed) to every datapath
//                select and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t      state_i,
    input  logic        mem_ready_i,
    input  logic        zero_i,
    input  logic [2:0]  funct3_i,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        illegal_o
);

    // Per-state control decode; everything defaults to 0 so each state only
    // lists the signals it actually drives.
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = ALU_A_PC;
        alu_src_b_o  = ALU_B_RS2;
        alu_op_o     = ALU_OP_ADD;
        illegal_o    = 1'b0;

        case (state_i)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read; both the
                // IR and the PC only commit on the cycle memory completes.
                mem_read_o  = 1'b1;
                iord_o      = 1'b0;
                alu_src_a_o = ALU_A_PC;
                alu_src_b_o = ALU_B_FOUR;
                alu_op_o    = ALU_OP_ADD;
                pc_src_o    = 1'b0;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target (old PC + imm) into ALUOut.
                alu_src_a_o = ALU_A_OLD_PC;
                alu_src_b_o = ALU_B_IMM;
                alu_op_o    = ALU_OP_ADD;
            end
            S_EXEC_R: begin
                alu_src_a_o = ALU_A_RS1;
                alu_src_b_o = ALU_B_RS2;
                alu_op_o    = ALU_OP_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a_o = ALU_A_RS1;
                alu_src_b_o = ALU_B_IMM;
                alu_op_o    = ALU_OP_ITYPE;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = ALU_A_RS1;
                alu_src_b_o = ALU_B_IMM;
                alu_op_o    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_WB_ALU: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b0;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_BRANCH: begin
                // rs1 - rs2 sets the zero flag; the target already sits in
                // ALUOut from DECODE.
                alu_src_a_o = ALU_A_RS1;
                alu_src_b_o = ALU_B_RS2;
                alu_op_o    = ALU_OP_SUB;
                pc_src_o    = 1'b1;
                pc_write_o  = branch_taken(funct3_i, zero_i);
            end
            S_HALT: begin
                illegal_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : multicycle_ctrl_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM for the RV32I-subset datapath.
//                Holds the state register, next-state logic and the retired
//                instruction counter; output decode is delegated to
//                multicycle_ctrl_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        illegal_o,
    output logic [31:0] retired_o,
    output logic [3:0]  state_o
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_retire;
    logic [31:0] r_retired;

    // Next-state selection; w_retire flags the transitions that complete an
    // instruction and return to FETCH.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready_i) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_R:               w_next_state = S_EXEC_R;
                    OP_I:               w_next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  w_next_state = S_MEM_ADDR;
                    OP_BRANCH:          w_next_state = S_BRANCH;
                    default:            w_next_state = S_HALT;
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                w_next_state = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                // Only loads and stores reach here, so anything that is not
                // a store is a load.
                w_next_state = (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    w_next_state = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_HALT: begin
                // Only reset leaves HALT.
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, free-running with natural wrap.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= 32'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    multicycle_ctrl_decode u_decode (
        .state_i      (r_state),
        .mem_ready_i  (mem_ready_i),
        .zero_i       (zero_i),
        .funct3_i     (funct3_i),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .illegal_o    (illegal_o)
    );

    assign retired_o = r_retired;
    assign state_o   = r_state;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. A directed table of
//                per-cycle vectors, hand-written reset / halt / wrap
//                sequences, and random instruction streams expanded into
//                expected per-cycle control words by an instruction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic       pcw, pcsrc, iord, mrd, mwr, irw, rw, m2r;
        logic [1:0] a, b, op;
        logic       ill;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        z;
        logic        rdy;
        ctl_t        exp;
        logic [31:0] ret;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode_i = 7'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic        zero_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        pc_write_o, pc_src_o, iord_o, mem_read_o, mem_write_o;
    logic        ir_write_o, reg_write_o, mem_to_reg_o, illegal_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [31:0] retired_o;
    logic [3:0]  state_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_retired = 32'd0;
    vec_t        vq[$];
    vec_t        tbl[21];

    multicycle_ctrl dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .iord_o       (iord_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .illegal_o    (illegal_o),
        .retired_o    (retired_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    // en = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg}
    function automatic ctl_t mk(input state_t st, input logic [7:0] en,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] op);
        ctl_t c;
        {c.pcw, c.pcsrc, c.iord, c.mrd, c.mwr, c.irw, c.rw, c.m2r} = en;
        c.a   = a;
        c.b   = b;
        c.op  = op;
        c.ill = (st == S_HALT);
        c.st  = st;
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c.pcw = pc_write_o;   c.pcsrc = pc_src_o;   c.iord = iord_o;
        c.mrd = mem_read_o;   c.mwr = mem_write_o;  c.irw = ir_write_o;
        c.rw  = reg_write_o;  c.m2r = mem_to_reg_o;
        c.a   = alu_src_a_o;  c.b = alu_src_b_o;    c.op = alu_op_o;
        c.ill = illegal_o;    c.st = state_o;
        return c;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rf3();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic check_vec(input string name, input vec_t v);
        ctl_t act;
        act = observed();
        n_vec++;
        if (act !== v.exp) begin
            n_err++;
            $display("FAIL %s vec %0d ctl: got %h want %h", name, n_vec, act, v.exp);
        end
        if (retired_o !== v.ret) begin
            n_err++;
            $display("FAIL %s vec %0d retired: got %h want %h", name, n_vec, retired_o, v.ret);
        end
        if (mem_read_o && mem_write_o) begin
            n_err++;
            $display("FAIL %s vec %0d mem_rw_both: got 1 want 0", name, n_vec);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        opcode_i    = v.opc;
        funct3_i    = v.f3;
        zero_i      = v.z;
        mem_ready_i = v.rdy;
        @(negedge clk_i);
        check_vec(name, v);
        @(posedge clk_i);
        #1;
    endtask

    task automatic flush(input string name);
        vec_t v;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            apply(name, v);
        end
    endtask

    task automatic push(input logic [6:0] opc, input logic [2:0] f3,
                        input logic z, input logic rdy, input state_t st,
                        input logic [7:0] en, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] op);
        vec_t v;
        v.opc = opc;  v.f3 = f3;  v.z = z;  v.rdy = rdy;
        v.exp = mk(st, en, a, b, op);
        v.ret = model_retired;
        vq.push_back(v);
    endtask

    task automatic push_idle();
        push(7'($urandom), rf3(), rb(), rb(), S_IDLE, 8'h00, 2'b00, 2'b00, 2'b00);
    endtask

    // Async reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        vec_t v;
        rst_n = 1'b0;
        #1;
        v.opc = opcode_i;  v.f3 = funct3_i;  v.z = zero_i;  v.rdy = mem_ready_i;
        v.exp = mk(S_IDLE, 8'h00, 2'b00, 2'b00, 2'b00);
        v.ret = 32'd0;
        check_vec("reset", v);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        model_retired = 32'd0;
    endtask

    // Instruction-level model: expands one instruction into its expected
    // cycles. wf = fetch wait cycles, wm = memory wait cycles (or the number
    // of HALT cycles to observe for an unsupported opcode).
    task automatic add_instr(input logic [6:0] opc, input logic [2:0] f3,
                             input logic z, input int wf, input int wm,
                             output bit halted);
        logic taken;
        halted = 1'b0;
        for (int i = 0; i < wf; i++)
            push(opc, rf3(), rb(), 1'b0, S_FETCH, 8'b0001_0000, 2'b00, 2'b01, 2'b00);
        push(opc, rf3(), rb(), 1'b1, S_FETCH, 8'b1001_0100, 2'b00, 2'b01, 2'b00);
        push(opc, rf3(), rb(), rb(), S_DECODE, 8'h00, 2'b10, 2'b10, 2'b00);
        case (opc)
            7'b0110011: begin
                push(opc, rf3(), rb(), rb(), S_EXEC_R, 8'h00, 2'b01, 2'b00, 2'b10);
                push(opc, rf3(), rb(), rb(), S_WB_ALU, 8'b0000_0010, 2'b00, 2'b00, 2'b00);
            end
            7'b0010011: begin
                push(opc, rf3(), rb(), rb(), S_EXEC_I, 8'h00, 2'b01, 2'b10, 2'b11);
                push(opc, rf3(), rb(), rb(), S_WB_ALU, 8'b0000_0010, 2'b00, 2'b00, 2'b00);
            end
            7'b0000011: begin
                push(opc, rf3(), rb(), rb(), S_MEM_ADDR, 8'h00, 2'b01, 2'b10, 2'b00);
                for (int i = 0; i < wm; i++)
                    push(opc, rf3(), rb(), 1'b0, S_MEM_RD, 8'b0011_0000, 2'b00, 2'b00, 2'b00);
                push(opc, rf3(), rb(), 1'b1, S_MEM_RD, 8'b0011_0000, 2'b00, 2'b00, 2'b00);
                push(opc, rf3(), rb(), rb(), S_WB_MEM, 8'b0000_0011, 2'b00, 2'b00, 2'b00);
            end
            7'b0100011: begin
                push(opc, rf3(), rb(), rb(), S_MEM_ADDR, 8'h00, 2'b01, 2'b10, 2'b00);
                for (int i = 0; i < wm; i++)
                    push(opc, rf3(), rb(), 1'b0, S_MEM_WR, 8'b0010_1000, 2'b00, 2'b00, 2'b00);
                push(opc, rf3(), rb(), 1'b1, S_MEM_WR, 8'b0010_1000, 2'b00, 2'b00, 2'b00);
            end
            7'b1100011: begin
                taken = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? ~z : 1'b0);
                push(opc, f3, z, rb(), S_BRANCH, {taken, 1'b1, 6'b0}, 2'b01, 2'b00, 2'b01);
            end
            default: begin
                for (int i = 0; i < wm; i++)
                    push(7'($urandom), rf3(), rb(), rb(), S_HALT, 8'h00, 2'b00, 2'b00, 2'b00);
                halted = 1'b1;
            end
        endcase
        if (!halted) model_retired = model_retired + 32'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit       h;
        int       pick;
        logic [6:0] opc;

        // Directed table: R-type, load with 3 wait cycles, beq taken, bne not taken.
        tbl[0]  = '{7'h33, 3'd0, 1'b0, 1'b1, mk(S_IDLE,     8'h00,        2'b00, 2'b00, 2'b00), 32'd0};
        tbl[1]  = '{7'h33, 3'd0, 1'b0, 1'b1, mk(S_FETCH,    8'b1001_0100, 2'b00, 2'b01, 2'b00), 32'd0};
        tbl[2]  = '{7'h33, 3'd0, 1'b0, 1'b1, mk(S_DECODE,   8'h00,        2'b10, 2'b10, 2'b00), 32'd0};
        tbl[3]  = '{7'h33, 3'd0, 1'b0, 1'b1, mk(S_EXEC_R,   8'h00,        2'b01, 2'b00, 2'b10), 32'd0};
        tbl[4]  = '{7'h33, 3'd0, 1'b0, 1'b1, mk(S_WB_ALU,   8'b0000_0010, 2'b00, 2'b00, 2'b00), 32'd0};
        tbl[5]  = '{7'h03, 3'd2, 1'b0, 1'b1, mk(S_FETCH,    8'b1001_0100, 2'b00, 2'b01, 2'b00), 32'd1};
        tbl[6]  = '{7'h03, 3'd2, 1'b0, 1'b1, mk(S_DECODE,   8'h00,        2'b10, 2'b10, 2'b00), 32'd1};
        tbl[7]  = '{7'h03, 3'd2, 1'b0, 1'b1, mk(S_MEM_ADDR, 8'h00,        2'b01, 2'b10, 2'b00), 32'd1};
        tbl[8]  = '{7'h03, 3'd2, 1'b0, 1'b0, mk(S_MEM_RD,   8'b0011_0000, 2'b00, 2'b00, 2'b00), 32'd1};
        tbl[9]  = '{7'h03, 3'd2, 1'b1, 1'b0, mk(S_MEM_RD,   8'b0011_0000, 2'b00, 2'b00, 2'b00), 32'd1};
        tbl[10] = '{7'h03, 3'd2, 1'b0, 1'b0, mk(S_MEM_RD,   8'b0011_0000, 2'b00, 2'b00, 2'b00), 32'd1};
        tbl[11] = '{7'h03, 3'd2, 1'b0, 1'b1, mk(S_MEM_RD,   8'b0011_0000, 2'b00, 2'b00, 2'b00), 32'd1};
        tbl[12] = '{7'h03, 3'd2, 1'b0, 1'b0, mk(S_WB_MEM,   8'b0000_0011, 2'b00, 2'b00, 2'b00), 32'd1};
        tbl[13] = '{7'h63, 3'd0, 1'b1, 1'b0, mk(S_FETCH,    8'b0001_0000, 2'b00, 2'b01, 2'b00), 32'd2};
        tbl[14] = '{7'h63, 3'd0, 1'b1, 1'b1, mk(S_FETCH,    8'b1001_0100, 2'b00, 2'b01, 2'b00), 32'd2};
        tbl[15] = '{7'h63, 3'd0, 1'b1, 1'b1, mk(S_DECODE,   8'h00,        2'b10, 2'b10, 2'b00), 32'd2};
        tbl[16] = '{7'h63, 3'd0, 1'b1, 1'b1, mk(S_BRANCH,   8'b1100_0000, 2'b01, 2'b00, 2'b01), 32'd2};
        tbl[17] = '{7'h63, 3'd1, 1'b1, 1'b1, mk(S_FETCH,    8'b1001_0100, 2'b00, 2'b01, 2'b00), 32'd3};
        tbl[18] = '{7'h63, 3'd1, 1'b1, 1'b1, mk(S_DECODE,   8'h00,        2'b10, 2'b10, 2'b00), 32'd3};
        tbl[19] = '{7'h63, 3'd1, 1'b1, 1'b1, mk(S_BRANCH,   8'b0100_0000, 2'b01, 2'b00, 2'b01), 32'd3};
        tbl[20] = '{7'h63, 3'd1, 1'b1, 1'b0, mk(S_FETCH,    8'b0001_0000, 2'b00, 2'b01, 2'b00), 32'd4};

        repeat (2) @(posedge clk_i);
        do_reset();
        for (int i = 0; i < 21; i++) apply("tbl", tbl[i]);

        // Unsupported opcode: HALT for 12 cycles, retired count frozen at 1.
        do_reset();
        push_idle();
        add_instr(7'h33, 3'd0, 1'b0, 0, 0, h);
        add_instr(7'h7F, 3'd0, 1'b0, 0, 12, h);
        flush("halt");

        // Reset pulsed while a store is waiting in MEM_WR.
        do_reset();
        push_idle();
        add_instr(7'h33, 3'd0, 1'b0, 0, 0, h);
        push(7'h23, 3'd2, 1'b0, 1'b1, S_FETCH, 8'b1001_0100, 2'b00, 2'b01, 2'b00);
        push(7'h23, 3'd2, 1'b0, 1'b1, S_DECODE, 8'h00, 2'b10, 2'b10, 2'b00);
        push(7'h23, 3'd2, 1'b0, 1'b0, S_MEM_ADDR, 8'h00, 2'b01, 2'b10, 2'b00);
        push(7'h23, 3'd2, 1'b0, 1'b0, S_MEM_WR, 8'b0010_1000, 2'b00, 2'b00, 2'b00);
        flush("st_pre");
        mem_ready_i = 1'b1;
        #2;
        do_reset();
        push_idle();
        push(7'h23, 3'd2, 1'b0, 1'b0, S_FETCH, 8'b0001_0000, 2'b00, 2'b01, 2'b00);
        flush("st_rst");

        // Counter wrap: preload all-ones, then retire a store and an R-type.
        do_reset();
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        model_retired = 32'hFFFF_FFFF;
        push_idle();
        add_instr(7'h23, 3'd0, 1'b0, 1, 2, h);
        add_instr(7'h33, 3'd0, 1'b0, 0, 0, h);
        flush("wrap");

        // Random instruction stream.
        do_reset();
        push_idle();
        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 11);
            case (pick)
                0, 1:    opc = 7'h33;
                2, 3:    opc = 7'h13;
                4, 5:    opc = 7'h03;
                6, 7:    opc = 7'h23;
                8, 9:    opc = 7'h63;
                default: opc = 7'($urandom);
            endcase
            add_instr(opc, rf3(), rb(), $urandom_range(0, 2), $urandom_range(0, 3), h);
            if (h) begin
                flush("rand");
                do_reset();
                push_idle();
            end
        end
        flush("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multicycle_ctrl
`default_nettype wire
